// File: rtl/overlay_pkg.sv
// Shared widths, mode bit positions, config record types and square helpers
// for the overlay compositor.
package overlay_pkg;

   localparam int COLOUR_W = 12;
   localparam int COORD_W  = 12;
   localparam int DIFF_W   = COORD_W + 1;   // signed pixel-to-object difference
   localparam int SQ_W     = 2 * DIFF_W;    // square of a difference
   localparam int SUM_W    = SQ_W + 1;      // dx^2 + dy^2
   localparam int MODE_W   = 4;

   localparam int MODE_EN      = 3;
   localparam int MODE_CIRCLE  = 2;
   localparam int MODE_OUTLINE = 1;
   localparam int MODE_BLINK   = 0;

   typedef struct packed {
      logic [COORD_W-1:0]  x;
      logic [COORD_W-1:0]  y;
      logic [COORD_W-1:0]  w;
      logic [COORD_W-1:0]  h;
      logic [COLOUR_W-1:0] colour;
      logic [MODE_W-1:0]   mode;
   } obj_cfg_t;

   typedef struct packed {
      obj_cfg_t         cfg;
      logic [SQ_W-1:0]  r2;    // radius squared
      logic [SQ_W-1:0]  ri2;   // inner (radius - outline) squared
   } obj_act_t;

   typedef struct packed {
      logic [COORD_W-1:0]  hcount;
      logic [COORD_W-1:0]  vcount;
      logic                hsync;
      logic                hblnk;
      logic                vsync;
      logic                vblnk;
      logic                nblank;
      logic [COLOUR_W-1:0] rgb;
   } pix_t;

   function automatic logic [SQ_W-1:0] square_u(input logic [COORD_W-1:0] a);
      logic [SQ_W-1:0] a_ext;
      a_ext = {{(SQ_W-COORD_W){1'b0}}, a};
      return a_ext * a_ext;
   endfunction

   // Inner ring radius squared; zero when the outline swallows the circle.
   function automatic logic [SQ_W-1:0] inner_r2(input logic [COORD_W-1:0] r, input int ow);
      if (r > COORD_W'(ow)) begin
         return square_u(r - COORD_W'(ow));
      end else begin
         return {SQ_W{1'b0}};
      end
   endfunction

endpackage

// File: rtl/overlay_obj_hit.sv
// One overlay object: stage 1 registers the signed differences and their
// squares; the hit flag is formed combinationally from those registers so the
// top can merge it into its second-stage output register.
module overlay_obj_hit
   import overlay_pkg::*;
#(
   parameter int OUTLINE_W = 2
) (
   input  logic               pclk,
   input  logic               rst_n,
   input  logic [COORD_W-1:0] hcount_i,
   input  logic [COORD_W-1:0] vcount_i,
   input  logic [COORD_W-1:0] x_i,
   input  logic [COORD_W-1:0] y_i,
   input  logic [COORD_W-1:0] w_i,
   input  logic [COORD_W-1:0] h_i,
   input  logic               circle_i,
   input  logic               outline_i,
   input  logic [SQ_W-1:0]    r2_i,
   input  logic [SQ_W-1:0]    ri2_i,
   output logic               hit_o
);

   localparam logic [COORD_W-1:0] OW_C  = COORD_W'(OUTLINE_W);
   localparam logic [COORD_W-1:0] OW2_C = COORD_W'(2 * OUTLINE_W);

   logic signed [DIFF_W-1:0] dx_d, dy_d, dx_q, dy_q;
   logic signed [SQ_W-1:0]   dx_ext_s, dy_ext_s;
   logic [SQ_W-1:0]          dx2_d, dy2_d, dx2_q, dy2_q;

   logic [COORD_W-1:0] dxu_s, dyu_s;
   logic               in_x_s, in_y_s, inner_x_s, inner_y_s, thick_s, rect_s;
   logic [SUM_W-1:0]   sum_s;
   logic               circ_in_s, circ_s;

   // Stage-1 next state: pixel minus object origin, sign-extended and squared.
   always_comb begin
      dx_d     = $signed({1'b0, hcount_i}) - $signed({1'b0, x_i});
      dy_d     = $signed({1'b0, vcount_i}) - $signed({1'b0, y_i});
      dx_ext_s = {{(SQ_W-DIFF_W){dx_d[DIFF_W-1]}}, dx_d};
      dy_ext_s = {{(SQ_W-DIFF_W){dy_d[DIFF_W-1]}}, dy_d};
      dx2_d    = dx_ext_s * dx_ext_s;
      dy2_d    = dy_ext_s * dy_ext_s;
   end

   // Stage-1 registers.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         dx_q  <= {DIFF_W{1'b0}};
         dy_q  <= {DIFF_W{1'b0}};
         dx2_q <= {SQ_W{1'b0}};
         dy2_q <= {SQ_W{1'b0}};
      end else begin
         dx_q  <= dx_d;
         dy_q  <= dy_d;
         dx2_q <= dx2_d;
         dy2_q <= dy2_d;
      end
   end

   // Stage-2 comparisons: rectangle span / inner span, circle radius / ring.
   always_comb begin
      dxu_s     = dx_q[COORD_W-1:0];
      dyu_s     = dy_q[COORD_W-1:0];
      in_x_s    = !dx_q[DIFF_W-1] && (dxu_s < w_i);
      in_y_s    = !dy_q[DIFF_W-1] && (dyu_s < h_i);
      thick_s   = (w_i > OW2_C) && (h_i > OW2_C);
      inner_x_s = (dxu_s >= OW_C) && (dxu_s < (w_i - OW_C));
      inner_y_s = (dyu_s >= OW_C) && (dyu_s < (h_i - OW_C));
      if (outline_i && thick_s) begin
         rect_s = in_x_s && in_y_s && !(inner_x_s && inner_y_s);
      end else begin
         rect_s = in_x_s && in_y_s;
      end
      sum_s     = {1'b0, dx2_q} + {1'b0, dy2_q};
      circ_in_s = (sum_s <= {1'b0, r2_i});
      if (outline_i && (w_i > OW_C)) begin
         circ_s = circ_in_s && (sum_s > {1'b0, ri2_i});
      end else begin
         circ_s = circ_in_s;
      end
      if (circle_i) begin
         hit_o = circ_s;
      end else begin
         hit_o = rect_s;
      end
   end

endmodule

// File: rtl/draw_overlay.sv
// Overlay compositor: N_OBJ rectangles/circles with double-buffered config,
// frame-synchronous commit, blink and fixed-priority colour mux, 2-cycle latency.
module draw_overlay
   import overlay_pkg::*;
#(
   parameter int N_OBJ        = 4,
   parameter int OUTLINE_W    = 2,
   parameter int BLINK_FRAMES = 30,
   parameter int IDXW         = 3
) (
   input  logic                pclk,
   input  logic                rst_n,
   input  logic [COORD_W-1:0]  hcount_in,
   input  logic [COORD_W-1:0]  vcount_in,
   input  logic                hsync_in,
   input  logic                hblnk_in,
   input  logic                vsync_in,
   input  logic                vblnk_in,
   input  logic [COLOUR_W-1:0] rgb_in,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [IDXW-1:0]     cfg_idx,
   input  logic [COORD_W-1:0]  cfg_x,
   input  logic [COORD_W-1:0]  cfg_y,
   input  logic [COORD_W-1:0]  cfg_w,
   input  logic [COORD_W-1:0]  cfg_h,
   input  logic [COLOUR_W-1:0] cfg_colour,
   input  logic [MODE_W-1:0]   cfg_mode,
   output logic [COORD_W-1:0]  hcount_out,
   output logic [COORD_W-1:0]  vcount_out,
   output logic                hsync_out,
   output logic                hblnk_out,
   output logic                vsync_out,
   output logic                vblnk_out,
   output logic [COLOUR_W-1:0] rgb_out,
   output logic                nblank_out
);

   localparam int               FRAME_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);

   obj_cfg_t           shadow_q [N_OBJ];
   obj_act_t           active_q [N_OBJ];
   obj_cfg_t           cfg_in_s;
   logic               vblnk_prev_q, ready_en_q, blink_phase_q;
   logic [FRAME_W-1:0] frame_q;
   logic               commit_s, wr_s;
   pix_t               pix_in_s, s1_q, s2_d, s2_q;
   logic [N_OBJ-1:0]   hit_s, show_s;

   assign commit_s  = vblnk_in & ~vblnk_prev_q;
   assign cfg_ready = ready_en_q & ~commit_s;
   assign wr_s      = cfg_valid & cfg_ready & ({1'b0, cfg_idx} < (IDXW+1)'(N_OBJ));

   // Pack the incoming config write and the incoming pixel.
   always_comb begin
      cfg_in_s        = '{x: cfg_x, y: cfg_y, w: cfg_w, h: cfg_h,
                          colour: cfg_colour, mode: cfg_mode};
      pix_in_s        = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                          hblnk: hblnk_in, vsync: vsync_in, vblnk: vblnk_in,
                          nblank: ~(hblnk_in | vblnk_in), rgb: rgb_in};
   end

   // Vblank edge detect, handshake enable and blink frame counter.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         vblnk_prev_q  <= 1'b0;
         ready_en_q    <= 1'b0;
         blink_phase_q <= 1'b0;
         frame_q       <= {FRAME_W{1'b0}};
      end else begin
         vblnk_prev_q <= vblnk_in;
         ready_en_q   <= 1'b1;
         if (commit_s) begin
            if (frame_q == FRAME_LAST) begin
               frame_q       <= {FRAME_W{1'b0}};
               blink_phase_q <= ~blink_phase_q;
            end else begin
               frame_q <= frame_q + FRAME_W'(1);
            end
         end
      end
   end

   // Shadow registers take accepted writes; commit copies all of them to the
   // active set together with the precomputed circle thresholds.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_OBJ; i++) begin
            shadow_q[i] <= '0;
            active_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_OBJ; i++) begin
            if (wr_s && (cfg_idx == IDXW'(i))) begin
               shadow_q[i] <= cfg_in_s;
            end
            if (commit_s) begin
               active_q[i] <= '{cfg: shadow_q[i], r2: square_u(shadow_q[i].w),
                                ri2: inner_r2(shadow_q[i].w, OUTLINE_W)};
            end
         end
      end
   end

   for (genvar g = 0; g < N_OBJ; g++) begin : g_obj
      overlay_obj_hit #(.OUTLINE_W(OUTLINE_W)) u_hit (
         .pclk      (pclk),
         .rst_n     (rst_n),
         .hcount_i  (hcount_in),
         .vcount_i  (vcount_in),
         .x_i       (active_q[g].cfg.x),
         .y_i       (active_q[g].cfg.y),
         .w_i       (active_q[g].cfg.w),
         .h_i       (active_q[g].cfg.h),
         .circle_i  (active_q[g].cfg.mode[MODE_CIRCLE]),
         .outline_i (active_q[g].cfg.mode[MODE_OUTLINE]),
         .r2_i      (active_q[g].r2),
         .ri2_i     (active_q[g].ri2),
         .hit_o     (hit_s[g])
      );
      assign show_s[g] = hit_s[g] & active_q[g].cfg.mode[MODE_EN]
                       & ~(active_q[g].cfg.mode[MODE_BLINK] & blink_phase_q);
   end

   // Priority mux: walk from highest index down so the lowest visible index wins.
   always_comb begin
      s2_d = s1_q;
      for (int i = N_OBJ - 1; i >= 0; i--) begin
         s2_d.rgb = show_s[i] ? active_q[i].cfg.colour : s2_d.rgb;
      end
   end

   // Two-stage timing pipeline; stage 2 doubles as the output register.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= pix_in_s;
         s2_q <= s2_d;
      end
   end

   assign hcount_out = s2_q.hcount;
   assign vcount_out = s2_q.vcount;
   assign hsync_out  = s2_q.hsync;
   assign hblnk_out  = s2_q.hblnk;
   assign vsync_out  = s2_q.vsync;
   assign vblnk_out  = s2_q.vblnk;
   assign nblank_out = s2_q.nblank;
   assign rgb_out    = s2_q.rgb;

endmodule

// File: tb/tb_draw_overlay.sv
// Directed bench for draw_overlay: hand-computed pixel colours, commit
// handshake, blink cadence, outlines, index discard and mid-line reset.
module tb_draw_overlay;

   logic        pclk = 1'b0;
   logic        rst_n;
   logic [11:0] hcount_in, vcount_in, rgb_in;
   logic        hsync_in, hblnk_in, vsync_in, vblnk_in;
   logic        cfg_valid, cfg_ready;
   logic [2:0]  cfg_idx;
   logic [11:0] cfg_x, cfg_y, cfg_w, cfg_h, cfg_colour;
   logic [3:0]  cfg_mode;
   logic [11:0] hcount_out, vcount_out, rgb_out;
   logic        hsync_out, hblnk_out, vsync_out, vblnk_out, nblank_out;

   int n_tests = 0;
   int n_fail  = 0;

   draw_overlay #(.N_OBJ(4), .OUTLINE_W(2), .BLINK_FRAMES(2), .IDXW(3)) dut (
      .pclk(pclk), .rst_n(rst_n),
      .hcount_in(hcount_in), .vcount_in(vcount_in),
      .hsync_in(hsync_in), .hblnk_in(hblnk_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
      .rgb_in(rgb_in),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_idx(cfg_idx),
      .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_w(cfg_w), .cfg_h(cfg_h),
      .cfg_colour(cfg_colour), .cfg_mode(cfg_mode),
      .hcount_out(hcount_out), .vcount_out(vcount_out),
      .hsync_out(hsync_out), .hblnk_out(hblnk_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
      .rgb_out(rgb_out), .nblank_out(nblank_out)
   );

   // Pixel clock, 10 ns period.
   always #5 pclk = ~pclk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cfg_write(input logic [2:0] idx, input logic [11:0] x, input logic [11:0] y,
                            input logic [11:0] w, input logic [11:0] h,
                            input logic [11:0] col, input logic [3:0] mode);
      @(negedge pclk);
      cfg_valid = 1'b1; cfg_idx = idx; cfg_x = x; cfg_y = y; cfg_w = w; cfg_h = h;
      cfg_colour = col; cfg_mode = mode;
      @(negedge pclk);
      cfg_valid = 1'b0;
   endtask

   // Present one pixel, follow it with a different one, check the first
   // exactly two clocks after it was captured.
   task automatic probe(input string tag, input logic [11:0] h, input logic [11:0] v,
                        input logic [11:0] bg, input logic [11:0] exp_rgb);
      @(negedge pclk);
      hcount_in = h; vcount_in = v; rgb_in = bg;
      hsync_in = 1'b1; hblnk_in = 1'b0; vsync_in = 1'b0; vblnk_in = 1'b0;
      @(negedge pclk);
      hcount_in = 12'd0; vcount_in = 12'd0; rgb_in = 12'hABC; hsync_in = 1'b0;
      @(negedge pclk);
      check_eq({tag, ".rgb"},    32'(rgb_out),    32'(exp_rgb));
      check_eq({tag, ".hcount"}, 32'(hcount_out), 32'(h));
      check_eq({tag, ".vcount"}, 32'(vcount_out), 32'(v));
      check_eq({tag, ".hsync"},  32'(hsync_out),  32'd1);
      check_eq({tag, ".nblank"}, 32'(nblank_out), 32'd1);
   endtask

   // Vblank rise (commit), optionally with a write offered in the commit cycle.
   task automatic commit(input string tag, input bit sneak);
      @(negedge pclk);
      vblnk_in = 1'b1; vsync_in = 1'b1; hsync_in = 1'b0;
      if (sneak) begin
         cfg_valid = 1'b1; cfg_idx = 3'd0; cfg_x = 12'd100; cfg_y = 12'd100;
         cfg_w = 12'd100; cfg_h = 12'd100; cfg_colour = 12'h0FF; cfg_mode = 4'b1001;
      end
      #1 check_eq({tag, ".ready_in_commit"}, 32'(cfg_ready), 32'd0);
      @(negedge pclk);
      cfg_valid = 1'b0;
      #1 check_eq({tag, ".ready_after"}, 32'(cfg_ready), 32'd1);
      @(negedge pclk);
      check_eq({tag, ".vblnk_out"},  32'(vblnk_out),  32'd1);
      check_eq({tag, ".nblank_out"}, 32'(nblank_out), 32'd0);
      vblnk_in = 1'b0; vsync_in = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      hcount_in = 12'd0; vcount_in = 12'd0; rgb_in = 12'd0;
      hsync_in = 1'b0; hblnk_in = 1'b0; vsync_in = 1'b0; vblnk_in = 1'b0;
      cfg_valid = 1'b0; cfg_idx = 3'd0; cfg_x = 12'd0; cfg_y = 12'd0;
      cfg_w = 12'd0; cfg_h = 12'd0; cfg_colour = 12'd0; cfg_mode = 4'd0;
      #12;
      check_eq("reset.rgb",    32'(rgb_out),    32'd0);
      check_eq("reset.hcount", 32'(hcount_out), 32'd0);
      check_eq("reset.ready",  32'(cfg_ready),  32'd0);
      check_eq("reset.nblank", 32'(nblank_out), 32'd0);
      @(negedge pclk);
      rst_n = 1'b1;

      probe("pass", 12'd10, 12'd20, 12'h123, 12'h123);

      // Filled rectangle, visible only after commit.
      cfg_write(3'd0, 12'd100, 12'd100, 12'd100, 12'd100, 12'h00F, 4'b1000);
      probe("rect.precommit", 12'd150, 12'd150, 12'h555, 12'h555);
      commit("c1", 1'b0);
      probe("rect.tl",    12'd100, 12'd100, 12'h555, 12'h00F);
      probe("rect.br",    12'd199, 12'd199, 12'h555, 12'h00F);
      probe("rect.right", 12'd200, 12'd150, 12'h555, 12'h555);
      probe("rect.left",  12'd99,  12'd100, 12'h555, 12'h555);

      // Filled circle r=50 at (500,150).
      cfg_write(3'd1, 12'd500, 12'd150, 12'd50, 12'd0, 12'h0F0, 4'b1100);
      commit("c2", 1'b0);
      probe("circ.edge",   12'd550, 12'd150, 12'h555, 12'h0F0);
      probe("circ.diag",   12'd536, 12'd186, 12'h555, 12'h555);
      probe("circ.centre", 12'd500, 12'd150, 12'h555, 12'h0F0);
      probe("circ.lout",   12'd449, 12'd150, 12'h555, 12'h555);
      probe("circ.lin",    12'd450, 12'd150, 12'h555, 12'h0F0);

      // Mid-frame colour change held until commit.
      cfg_write(3'd0, 12'd100, 12'd100, 12'd100, 12'd100, 12'hF00, 4'b1000);
      probe("recol.old", 12'd150, 12'd150, 12'h555, 12'h00F);
      commit("c3", 1'b0);
      probe("recol.new", 12'd150, 12'd150, 12'h555, 12'hF00);

      // Blinking obj0 over obj2; a write offered in the commit cycle is refused.
      cfg_write(3'd2, 12'd150, 12'd150, 12'd100, 12'd100, 12'hFF0, 4'b1000);
      cfg_write(3'd0, 12'd100, 12'd100, 12'd100, 12'd100, 12'hF00, 4'b1001);
      commit("c4", 1'b1);
      probe("blink.f4.ov",  12'd175, 12'd175, 12'h555, 12'hF00);
      probe("blink.f4.o2",  12'd240, 12'd240, 12'h555, 12'hFF0);
      probe("blink.f4.o0",  12'd120, 12'd120, 12'h555, 12'hF00);
      commit("c5", 1'b0);
      probe("blink.f5.ov",  12'd175, 12'd175, 12'h555, 12'hF00);
      commit("c6", 1'b0);
      probe("blink.f6.ov",  12'd175, 12'd175, 12'h555, 12'hFF0);
      probe("blink.f6.o0",  12'd120, 12'd120, 12'h555, 12'h555);
      commit("c7", 1'b0);
      probe("blink.f7.ov",  12'd175, 12'd175, 12'h555, 12'hFF0);
      commit("c8", 1'b0);
      probe("blink.f8.ov",  12'd175, 12'd175, 12'h555, 12'hF00);

      // Outline rectangle, outline circle, out-of-range index discarded.
      cfg_write(3'd3, 12'd300, 12'd300, 12'd10, 12'd10, 12'h0FF, 4'b1010);
      cfg_write(3'd7, 12'd300, 12'd300, 12'd10, 12'd10, 12'h111, 4'b1000);
      cfg_write(3'd1, 12'd500, 12'd150, 12'd50, 12'd0, 12'h0F0, 4'b1110);
      commit("c9", 1'b0);
      probe("orect.edge",   12'd301, 12'd305, 12'h555, 12'h0FF);
      probe("orect.inner",  12'd305, 12'd305, 12'h555, 12'h555);
      probe("orect.corner", 12'd309, 12'd309, 12'h555, 12'h0FF);
      probe("orect.inner2", 12'd302, 12'd302, 12'h555, 12'h555);
      probe("orect.out",    12'd310, 12'd305, 12'h555, 12'h555);
      probe("ocirc.centre", 12'd500, 12'd150, 12'h555, 12'h555);
      probe("ocirc.ring",   12'd549, 12'd150, 12'h555, 12'h0F0);
      probe("ocirc.hole",   12'd547, 12'd150, 12'h555, 12'h555);

      // Mid-line reset with a pending shadow write.
      cfg_write(3'd0, 12'd0, 12'd0, 12'd4000, 12'd4000, 12'h0F0, 4'b1000);
      @(negedge pclk);
      hcount_in = 12'd175; vcount_in = 12'd175; rgb_in = 12'h777; hsync_in = 1'b1;
      @(negedge pclk);
      @(negedge pclk);
      check_eq("prereset.rgb", 32'(rgb_out), 32'hF00);
      #2 rst_n = 1'b0;
      #1;
      check_eq("midrst.rgb",    32'(rgb_out),    32'd0);
      check_eq("midrst.hcount", 32'(hcount_out), 32'd0);
      check_eq("midrst.vcount", 32'(vcount_out), 32'd0);
      check_eq("midrst.hsync",  32'(hsync_out),  32'd0);
      check_eq("midrst.nblank", 32'(nblank_out), 32'd0);
      check_eq("midrst.ready",  32'(cfg_ready),  32'd0);
      @(negedge pclk);
      rst_n = 1'b1;
      probe("postrst.pass", 12'd175, 12'd175, 12'h777, 12'h777);
      commit("c10", 1'b0);
      probe("postrst.discard", 12'd175, 12'd175, 12'h777, 12'h777);
      probe("postrst.pass2",   12'd10,  12'd10,  12'h321, 12'h321);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
